// File: rtl/ntt_sched_ctrl.sv
// ntt_sched_ctrl: sequences a 256-point Kyber NTT/INTT (7 layers x 128
// butterflies). Each ISSUE cycle emits one coefficient-pair read plus a
// twiddle index. The read addresses are delayed by the RAM + butterfly latency
// to become in-place write addresses. Between layers the pipeline is drained
// so the next layer never reads stale data.
// Ports:
//   clk, rst (sync, active-low)     clock / reset
//   start, inv                      begin transform; 0 = NTT, 1 = INTT
//   busy, done                      running flag; one-cycle completion pulse
//   rd_en, rd_addr_a/b, tw_addr     poly RAM read pair and twiddle ROM index
//   bf_mode                         butterfly_core mode (0 NTT, 1 INTT)
//   wr_en, wr_addr_a/b              poly RAM write-back pair
module ntt_sched_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned BF_LAT = 5;
    localparam int unsigned PIPE   = RD_LAT + BF_LAT;
    localparam int unsigned AW     = 8;
    localparam int unsigned TWW    = 7;
    localparam int unsigned CW     = 7;
    localparam int unsigned LW     = 3;
    localparam int unsigned DW     = 3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_c, w_c_nxt;
    logic [LW-1:0]   r_layer, w_layer_nxt;
    logic [DW-1:0]   r_drain, w_drain_nxt;
    logic            r_inv, w_inv_nxt;

    logic [PIPE-1:0] r_pipe_en;
    logic [AW-1:0]   r_pipe_a [PIPE];
    logic [AW-1:0]   r_pipe_b [PIPE];

    // Next-state and counter control
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_layer_nxt = r_layer;
        w_drain_nxt = r_drain;
        w_inv_nxt   = r_inv;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_inv_nxt   = inv;
                    w_layer_nxt = '0;
                    w_c_nxt     = '0;
                    w_drain_nxt = '0;
                end
            end
            S_ISSUE: begin
                w_c_nxt = CW'(r_c + CW'(1));
                if (r_c == CW'(127)) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end
            end
            S_DRAIN: begin
                w_drain_nxt = DW'(r_drain + DW'(1));
                if (r_drain == DW'(PIPE - 1)) begin
                    if (r_layer == LW'(6)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_layer_nxt = LW'(r_layer + LW'(1));
                        w_c_nxt     = '0;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pair address: insert a 0 bit at position s of c; partner is +len
    logic [LW-1:0]  w_s;
    logic [AW-1:0]  w_len, w_c8, w_g, w_i, w_a, w_b;
    logic [8:0]     w_tw9;
    logic           w_issue;

    always_comb begin
        w_s     = r_inv ? LW'(r_layer + LW'(1)) : LW'(LW'(7) - r_layer);
        w_len   = AW'(1) << w_s;
        w_c8    = {1'b0, r_c};
        w_g     = w_c8 >> w_s;
        w_i     = w_c8 & AW'(w_len - AW'(1));
        w_a     = AW'(w_g << ({1'b0, w_s} + 4'd1)) | w_i;
        w_b     = w_a | w_len;
        w_tw9   = r_inv ? 9'(9'(9'd256 >> w_s) - 9'd1 - {1'b0, w_g})
                        : 9'(9'(9'd128 >> w_s) + {1'b0, w_g});
        w_issue = (r_state == S_ISSUE);
    end

    // State, counters, registered outputs and write-back delay line
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_c       <= '0;
            r_layer   <= '0;
            r_drain   <= '0;
            r_inv     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            bf_mode   <= '0;
            r_pipe_en <= '0;
            for (int k = 0; k < int'(PIPE); k++) begin
                r_pipe_a[k] <= '0;
                r_pipe_b[k] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_c       <= w_c_nxt;
            r_layer   <= w_layer_nxt;
            r_drain   <= w_drain_nxt;
            r_inv     <= w_inv_nxt;
            if (r_state == S_IDLE && start) begin
                bf_mode <= {1'b0, inv};
            end
            busy      <= (r_state == S_ISSUE) || (r_state == S_DRAIN);
            done      <= (r_state == S_DONE);
            rd_en     <= w_issue;
            rd_addr_a <= w_issue ? w_a : '0;
            rd_addr_b <= w_issue ? w_b : '0;
            tw_addr   <= w_issue ? TWW'(w_tw9) : '0;
            // rd_* are already zero when idle, so the line is fed 0 then
            r_pipe_en   <= {r_pipe_en[PIPE-2:0], rd_en};
            r_pipe_a[0] <= rd_addr_a;
            r_pipe_b[0] <= rd_addr_b;
            for (int k = 1; k < int'(PIPE); k++) begin
                r_pipe_a[k] <= r_pipe_a[k-1];
                r_pipe_b[k] <= r_pipe_b[k-1];
            end
        end
    end

    assign wr_en     = r_pipe_en[PIPE-1];
    assign wr_addr_a = r_pipe_a[PIPE-1];
    assign wr_addr_b = r_pipe_b[PIPE-1];

endmodule

// File: tb/tb_ntt_sched_ctrl.sv
// Directed bench for ntt_sched_ctrl: full NTT/INTT runs compared cycle by
// cycle against an independent schedule model, plus hand-computed spot values,
// ignored start/inv pulses and a mid-run reset.
module tb_ntt_sched_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, inv;
    logic       busy, done, rd_en, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;

    int n_checks = 0;
    int n_fail   = 0;

    ntt_sched_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_mode(bf_mode), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read issued at cycle n (n=0 is the cycle start is accepted)
    task automatic model(input int n, input bit m, output bit en,
                         output logic [7:0] a, output logic [7:0] b, output logic [6:0] tw);
        int q, k, s, len, g, i;
        en = 1'b0; a = '0; b = '0; tw = '0;
        if (n >= 1 && n <= 938) begin
            q = (n - 1) / 134;
            k = (n - 1) % 134;
            if (k < 128) begin
                s   = m ? q + 1 : 7 - q;
                len = 1 << s;
                g   = k / len;
                i   = k % len;
                en  = 1'b1;
                a   = 8'(g * 2 * len + i);
                b   = 8'(g * 2 * len + i + len);
                tw  = m ? 7'(256 / len - 1 - g) : 7'(128 / len + g);
            end
        end
    endtask

    function automatic logic [63:0] pack_dut();
        return 64'({rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en,
                    wr_addr_a, wr_addr_b, busy, done, bf_mode});
    endfunction

    // One full transform; noisy=1 adds ignored start/inv activity
    task automatic run(input bit m, input bit noisy);
        bit         ren, wen;
        logic [7:0] ra, rb, wa, wb, unused_a;
        logic [6:0] rt, wt;
        logic [63:0] exp;
        int         rd_cnt, wr_cnt, done_cnt, done_cyc;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        inv   = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n <= 945; n++) begin
            if (n > 0) tick();
            model(n, m, ren, ra, rb, rt);
            model(n - 6, m, wen, wa, wb, wt);
            exp = 64'({ren, ra, rb, rt, wen, wa, wb,
                       (n >= 1 && n <= 938), (n == 939), {1'b0, m}});
            check($sformatf("%s_cyc%0d", m ? "intt" : "ntt", n), pack_dut(), exp);
            if (rd_en) rd_cnt++;
            if (wr_en) wr_cnt++;
            if (done) begin done_cnt++; done_cyc = n; end
            if (!m && n == 1)   check("ntt_c1",   64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd0,   8'd128, 7'd1}));
            if (!m && n == 3)   check("ntt_c3",   64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd2,   8'd130, 7'd1}));
            if (!m && n == 128) check("ntt_c128", 64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd127, 8'd255, 7'd1}));
            if (!m && n == 807) check("ntt_l6c2", 64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd4,   8'd6,   7'd65}));
            if (!m && n == 932) check("ntt_l6end",64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd253, 8'd255, 7'd127}));
            if (m && n == 1)    check("intt_c1",  64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd0,   8'd2,   7'd127}));
            if (m && n == 3)    check("intt_c3",  64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd4,   8'd6,   7'd126}));
            if (m && n == 806)  check("intt_l6c1",64'({rd_addr_a, rd_addr_b, tw_addr}), 64'({8'd1,   8'd129, 7'd1}));
            if (n == 7)         check("wr_first", 64'({wr_en, wr_addr_a}), 64'({1'b1, 8'd0}));
            if (noisy) begin
                start = (n == 9 || n == 499);
                if (n == 299) inv = ~m;
            end
        end
        unused_a = wa;
        start = 1'b0;
        check("rd_count",   64'(rd_cnt),   64'd896);
        check("wr_count",   64'(wr_cnt),   64'd896);
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'd939);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; inv = 1'b0;
        repeat (3) tick();
        check("reset_outs", pack_dut(), 64'd0);
        rst = 1'b1;
        tick();
        check("idle_outs", pack_dut(), 64'd0);

        run(1'b0, 1'b1);
        run(1'b1, 1'b0);

        // mid-run reset during layer 3 (cycles 403..536)
        inv = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (450) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        tick();
        check("rst_mid_outs", pack_dut(), 64'd0);
        rst = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            check("post_rst_quiet", pack_dut(), 64'd0);
        end

        run(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
